nv_int_norm_pipe: RTL and testbench
===================================

NV_INT_NORM_PIPE -- requirements
Module: nv_int_norm_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning two's-complement operand width; legal range 4..128.
REQ-002 SHALL have derived localparam SHIFT_WIDTH, default ceil(log2(DATA_WIDTH)), meaning the width of the shift-count output.
REQ-003 SHALL have nvdla_core_clk  input  1  the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have nvdla_core_rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have in_pvld  input  1  upstream operand valid.
REQ-006 SHALL have in_prdy  output  1  block accepts an operand this cycle.
REQ-007 SHALL have in_pd  input  DATA_WIDTH  two's-complement operand.
REQ-008 SHALL have out_pvld  output  1  normalized result valid.
REQ-009 SHALL have out_prdy  input  1  downstream accepts the result.
REQ-010 SHALL have out_pd  output  DATA_WIDTH  operand left-shifted by out_shift, zero-filled at the LSBs.
REQ-011 SHALL have out_shift  output  SHIFT_WIDTH  redundant sign-bit count, i.e. the applied left shift.
REQ-012 SHALL have out_zero  output  1  high when the operand equals zero.

Function
REQ-013 The shift count SHALL be (number of contiguous MSB-side bits equal to in_pd[DATA_WIDTH-1]) minus 1, range 0..DATA_WIDTH-1.
REQ-014 For all-zeros and all-ones operands, the shift count SHALL be DATA_WIDTH-1.
REQ-015 The block SHALL be a two-stage pipeline: S1 registers the operand, shift count and zero flag; S2 registers the shifted data, shift count and zero flag.
REQ-016 Each stage SHALL hold one valid bit; a transfer occurs on a cycle when pvld and prdy are both high.
REQ-017 S1 ready SHALL be (!s1_vld || s2_ready); S2 ready SHALL be (!s2_vld || out_prdy); in_prdy SHALL equal S1 ready, combinational, with no dependence on in_pvld.
REQ-018 Latency SHALL be 2 cycles from the in_pd accept edge to out_pvld high, with out_prdy held high.
REQ-019 Throughput SHALL be 1 operand/cycle under continuous in_pvld and out_prdy, with no bubbles.
REQ-020 While out_pvld=1 and out_prdy=0, out_pd, out_shift and out_zero SHALL hold stable, and out_pvld SHALL stay high.
REQ-021 Under full stall, both stages SHALL fill; in_prdy SHALL drop only when S1 and S2 are valid and out_prdy=0.
REQ-022 On the same cycle out_prdy rises with both stages full, in_prdy SHALL be high and all three transfers (in->S1, S1->S2, S2->out) SHALL occur.
REQ-023 out_pd SHALL be the operand shifted left with bits shifted past the MSB discarded; after the shift, bit DATA_WIDTH-1 differs from bit DATA_WIDTH-2 unless the operand is 0 or -1.
REQ-024 Ordering SHALL be strictly FIFO; no operand may be dropped or duplicated.
REQ-025 Data registers SHALL load only on transfer, so they do not toggle when the valid is low.

Reset
REQ-026 While nvdla_core_rstn=0, s1_vld, s2_vld and out_pvld SHALL be 0, and out_pd, out_shift and out_zero SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operands immediately (asynchronously).
REQ-028 in_prdy SHALL be 1 on the first cycle after reset deassertion.

Verification (DATA_WIDTH=8)
REQ-029 Send in_pd=0x03 with out_prdy=1 -> 2 cycles later out_pd=0x60, out_shift=5, out_zero=0.
REQ-030 Send back-to-back 0x00, 0xFF, 0xF0, 0x40, 0xC0 -> out_pd/out_shift = 0x00/7 (zero=1), 0x80/7, 0x80/3, 0x40/0, 0x80/1 on consecutive cycles.
REQ-031 Hold out_prdy=0 and send 3 operands -> 2 are accepted, in_prdy=0 on the 3rd; out_pd stays stable; when out_prdy=1 the 3rd is accepted the same cycle, and all 3 arrive in order.
REQ-032 Assert nvdla_core_rstn=0 with both stages full -> out_pvld=0 with no clock edge; after release, in_prdy=1 and no stale output appears.
REQ-033 Random in_pvld/out_prdy, 10k operands -> scoreboard matches the reference shift/count model and the FIFO order, and the stable-while-stalled check passes.

Source files
------------

// File: rtl/nv_int_norm_pipe.sv
// Two-stage integer normalizer: counts redundant sign bits of a two's-complement
// operand and left-shifts it so the result's top two bits differ (except 0 / -1).
// S1 captures operand, shift count and zero flag; S2 captures the shifted result.
module nv_int_norm_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  localparam int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [DATA_WIDTH-1:0]  in_pd,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [DATA_WIDTH-1:0]  out_pd,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_zero
);

  logic                   w_s1_rdy;
  logic                   w_s2_rdy;
  logic                   w_s1_load;
  logic                   w_s2_load;
  logic [SHIFT_WIDTH-1:0] w_cnt;
  logic                   w_hit;
  logic                   w_zero;

  logic                   r_s1_vld;
  logic [DATA_WIDTH-1:0]  r_s1_pd;
  logic [SHIFT_WIDTH-1:0] r_s1_shift;
  logic                   r_s1_zero;

  logic                   r_s2_vld;
  logic [DATA_WIDTH-1:0]  r_s2_pd;
  logic [SHIFT_WIDTH-1:0] r_s2_shift;
  logic                   r_s2_zero;

  // A stage can take new data when it is empty or its content leaves this cycle.
  assign w_s2_rdy  = !r_s2_vld || out_prdy;
  assign w_s1_rdy  = !r_s1_vld || w_s2_rdy;
  assign w_s1_load = in_pvld && w_s1_rdy;
  assign w_s2_load = r_s1_vld && w_s2_rdy;
  assign in_prdy   = w_s1_rdy;

  assign w_zero = (in_pd == '0);

  // Count bits below the MSB that match it, stopping at the first that differs.
  always_comb begin
    w_cnt = '0;
    w_hit = 1'b0;
    for (int i = int'(DATA_WIDTH) - 2; i >= 0; i--) begin
      if (!w_hit) begin
        if (in_pd[i] == in_pd[DATA_WIDTH-1]) begin
          w_cnt = w_cnt + SHIFT_WIDTH'(1);
        end else begin
          w_hit = 1'b1;
        end
      end
    end
  end

  // S1 valid: refilled (or emptied) whenever the stage is ready.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s1_vld <= 1'b0;
    end else if (w_s1_rdy) begin
      r_s1_vld <= in_pvld;
    end
  end

  // S1 data: loads only on an accepted operand.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s1_pd    <= '0;
      r_s1_shift <= '0;
      r_s1_zero  <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_pd    <= in_pd;
      r_s1_shift <= w_cnt;
      r_s1_zero  <= w_zero;
    end
  end

  // S2 valid: takes S1's valid whenever S2 is ready.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s2_vld <= 1'b0;
    end else if (w_s2_rdy) begin
      r_s2_vld <= r_s1_vld;
    end
  end

  // S2 data: applies the shift; bits pushed past the MSB are dropped.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s2_pd    <= '0;
      r_s2_shift <= '0;
      r_s2_zero  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_pd    <= r_s1_pd << r_s1_shift;
      r_s2_shift <= r_s1_shift;
      r_s2_zero  <= r_s1_zero;
    end
  end

  assign out_pvld  = r_s2_vld;
  assign out_pd    = r_s2_pd;
  assign out_shift = r_s2_shift;
  assign out_zero  = r_s2_zero;

endmodule

// File: tb/tb_nv_int_norm_pipe.sv
// Self-checking bench for nv_int_norm_pipe at DATA_WIDTH=8: directed cases followed by
// randomized traffic scored against an arithmetic reference model.
module tb_nv_int_norm_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;

  logic          clk;
  logic          rstn;
  logic          in_pvld;
  logic          in_prdy;
  logic [DW-1:0] in_pd;
  logic          out_pvld;
  logic          out_prdy;
  logic [DW-1:0] out_pd;
  logic [SW-1:0] out_shift;
  logic          out_zero;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_pd;
  logic [SW-1:0] prev_shift;
  logic          prev_zero;

  nv_int_norm_pipe #(.DATA_WIDTH(DW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy),
    .in_pd          (in_pd),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_pd         (out_pd),
    .out_shift      (out_shift),
    .out_zero       (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Largest k such that v * 2^k still fits in a signed DW-bit value.
  function automatic int ref_shift(input logic [DW-1:0] v);
    int sv;
    int k;
    sv = int'($signed(v));
    k  = 0;
    for (int j = 1; j < int'(DW); j++) begin
      if (sv * (1 << j) >= -(1 << (DW - 1)) && sv * (1 << j) <= (1 << (DW - 1)) - 1) k = j;
    end
    return k;
  endfunction

  function automatic logic [DW-1:0] ref_pd(input logic [DW-1:0] v);
    int sv;
    sv = int'($signed(v));
    return DW'(sv * (1 << ref_shift(v)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample settled outputs, score the cycle, then advance to just past the next edge.
  task automatic tick();
    logic [DW-1:0] e;
    #1;
    if (prev_stall) begin
      chk("stall_vld", 32'(out_pvld), 32'd1);
      chk("stall_pd", 32'(out_pd), 32'(prev_pd));
      chk("stall_shift", 32'(out_shift), 32'(prev_shift));
      chk("stall_zero", 32'(out_zero), 32'(prev_zero));
    end
    prev_stall = out_pvld && !out_prdy;
    prev_pd    = out_pd;
    prev_shift = out_shift;
    prev_zero  = out_zero;
    if (out_pvld && out_prdy) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pd", 32'(out_pd), 32'(ref_pd(e)));
        chk("sb_shift", 32'(out_shift), 32'(ref_shift(e)));
        chk("sb_zero", 32'(out_zero), 32'(e == '0));
      end
    end
    if (in_pvld && in_prdy) exp_q.push_back(in_pd);
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] v30  [5];
  logic [DW-1:0] e30p [5];
  logic [SW-1:0] e30s [5];
  logic [DW-1:0] held_pd;
  logic [DW-1:0] corner [5];
  int            sent;
  int            cyc;

  initial begin
    v30  = '{8'h00, 8'hFF, 8'hF0, 8'h40, 8'hC0};
    e30p = '{8'h00, 8'h80, 8'h80, 8'h40, 8'h80};
    e30s = '{3'd7, 3'd7, 3'd3, 3'd0, 3'd1};
    corner = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01};

    rstn     = 1'b0;
    in_pvld  = 1'b0;
    in_pd    = '0;
    out_prdy = 1'b0;

    // Reset state.
    #2;
    chk("rst_out_pvld", 32'(out_pvld), 32'd0);
    chk("rst_out_pd", 32'(out_pd), 32'd0);
    chk("rst_out_shift", 32'(out_shift), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_prdy", 32'(in_prdy), 32'd1);
    chk("post_rst_out_pvld", 32'(out_pvld), 32'd0);

    // Single operand, latency of two edges.
    out_prdy = 1'b1;
    in_pvld  = 1'b1;
    in_pd    = 8'h03;
    #1;
    chk("lat_in_prdy", 32'(in_prdy), 32'd1);
    tick();
    in_pvld = 1'b0;
    chk("lat_early_vld", 32'(out_pvld), 32'd0);
    tick();
    chk("lat_vld", 32'(out_pvld), 32'd1);
    chk("lat_pd", 32'(out_pd), 32'h60);
    chk("lat_shift", 32'(out_shift), 32'd5);
    chk("lat_zero", 32'(out_zero), 32'd0);
    tick();
    chk("lat_after_vld", 32'(out_pvld), 32'd0);

    // Back-to-back stream: results on consecutive cycles.
    for (int c = 0; c < 7; c++) begin
      in_pvld = (c < 5);
      in_pd   = (c < 5) ? v30[c] : 8'h00;
      #1;
      if (c >= 2) begin
        chk("b2b_vld", 32'(out_pvld), 32'd1);
        chk("b2b_pd", 32'(out_pd), 32'(e30p[c-2]));
        chk("b2b_shift", 32'(out_shift), 32'(e30s[c-2]));
        chk("b2b_zero", 32'(out_zero), 32'(c == 2));
      end
      tick();
    end
    in_pvld = 1'b0;
    tick();
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Full stall: two accepted, third refused until downstream frees up.
    out_prdy = 1'b0;
    in_pvld  = 1'b1;
    in_pd    = 8'h05;
    #1;
    chk("stall_acc1", 32'(in_prdy), 32'd1);
    tick();
    in_pd = 8'h3A;
    #1;
    chk("stall_acc2", 32'(in_prdy), 32'd1);
    tick();
    in_pd = 8'hE1;
    #1;
    chk("stall_full_prdy", 32'(in_prdy), 32'd0);
    chk("stall_full_vld", 32'(out_pvld), 32'd1);
    held_pd = out_pd;
    tick();
    tick();
    chk("stall_held_pd", 32'(out_pd), 32'(held_pd));
    out_prdy = 1'b1;
    #1;
    chk("release_prdy", 32'(in_prdy), 32'd1);
    tick();
    in_pvld = 1'b0;
    repeat (3) tick();
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with both stages full.
    out_prdy = 1'b0;
    in_pvld  = 1'b1;
    in_pd    = 8'h12;
    tick();
    in_pd = 8'h9C;
    tick();
    in_pvld = 1'b0;
    #1;
    chk("pre_arst_vld", 32'(out_pvld), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_vld", 32'(out_pvld), 32'd0);
    chk("arst_pd", 32'(out_pd), 32'd0);
    chk("arst_shift", 32'(out_shift), 32'd0);
    chk("arst_prdy", 32'(in_prdy), 32'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    out_prdy = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rel_prdy", 32'(in_prdy), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk("arst_no_stale", 32'(out_pvld), 32'd0);
      tick();
    end

    // Randomized traffic against the reference model.
    sent = 0;
    cyc  = 0;
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 30000) begin
      in_pvld  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      out_prdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) in_pd = corner[$urandom_range(0, 4)];
      else in_pd = DW'($urandom);
      #1;
      if (in_pvld && in_prdy) sent++;
      tick();
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd10000);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
